servo_pwm_quad: RTL and testbench
=================================

Name: servo_pwm_quad

Overview:
- Downstream consumer of the four 8-bit joint angles produced by the key/switch angle-entry stage.
- Converts each angle (degrees, 0..ANGLE_MAX) into a standard hobby-servo PWM pulse: 50 Hz frame, 1.0–2.0 ms high time.
- Shadow registers update only on frame boundaries, so angle changes never produce truncated or runt pulses.
- Drives the four servo output pins directly.

Parameters:
- CLK_HZ, 50000000, system clock frequency. Must be an integer multiple of 1000000.
- PERIOD_US, 20000, frame length in microseconds.
- MIN_US, 1000, pulse width at angle 0.
- MAX_US, 2000, pulse width at angle ANGLE_MAX. Must be less than PERIOD_US.
- ANGLE_MAX, 180, largest legal angle. Larger inputs are clamped.
- SLEW_STEP, 2, maximum degrees of change per frame. Used only with SERVO_SLEW_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- angle1  in  8  channel 0 target angle, unsigned degrees.
- angle2  in  8  channel 1 target angle.
- angle3  in  8  channel 2 target angle.
- angle4  in  8  channel 3 target angle.
- ch_en  in  4  per-channel enable; bit i gates pwm[i].
- pwm  out  4  servo pulse outputs, registered.
- frame_start  out  1  one-cycle pulse marking the first cycle of each frame.

Behaviour:
- Reset (async, rst=1):
  - prescaler=0, us_cnt=0, pwm=4'b0000, frame_start=0.
  - Shadow widths = MIN_US; shadow enables = 0.
  - With the slew feature, current angles = 0.
- Prescaler: counts 0..DIV-1, where DIV=CLK_HZ/1000000. tick_us is asserted in the cycle where prescaler==DIV-1.
- us_cnt: on tick_us, increments 0..PERIOD_US-1 and wraps to 0.
- frame_start: registered; equals 1 for exactly one clk, in the cycle after us_cnt wraps PERIOD_US-1 -> 0. The first frame_start after reset release occurs PERIOD_US*DIV clocks after release.
- Shadow load, on the same clk edge that raises frame_start:
  - sh_en <= ch_en.
  - sh_w[i] <= width(a_i), with a_i = min(angle_i, ANGLE_MAX).
  - width(a) = MIN_US + floor(a*(MAX_US-MIN_US)/ANGLE_MAX). Intermediate width must be at least 8+log2(MAX_US-MIN_US)+1 bits, with no overflow.
  - Angle and enable inputs are sampled only on this edge. Changes at other times have no effect until the next frame.
- Output: pwm[i] <= sh_en[i] & (us_cnt < sh_w[i]), registered every clk.
  - Latency of one clk from the counter state.
  - High time per frame is exactly sh_w[i]*DIV clocks. Frame period is exactly PERIOD_US*DIV clocks.
- ch_en[i]=0 at a frame boundary: pwm[i] stays 0 for the whole frame. Re-enabling takes effect at the next boundary only.
- Reset asserted mid-pulse: pwm drops to 0 immediately (async). On release, counting restarts from 0 with shadow state at reset values, so no pulse appears in the first frame.
- All channels share one frame, so rising edges are simultaneous.

Optional Feature:
- Macro SERVO_SLEW_EN.
- Defined:
  - Per-channel register cur_i (8 bit, reset 0).
  - At each shadow load, cur_i moves toward a_i by min(|a_i-cur_i|, SLEW_STEP).
  - sh_w[i] <= width(updated cur_i), computed in the same edge.
  - cur_i keeps updating even when ch_en[i]=0.
- Undefined: no cur_i registers and no SLEW_STEP logic; sh_w is taken directly from a_i as above.

Test Plan (CLK_HZ=4000000, DIV=4, other defaults; macro undefined unless stated):
- Reset then release, all angles 90, ch_en=4'hF -> pwm=0 for the first 80000 clks. Then frame_start pulses, and each pwm is high 6000 clks (1500 us) with period 80000 clks.
- angle1=0, angle2=180, angle3=1, angle4=255 -> high times of 4000, 8000, 4020 (1005 us) and 8000 clks (clamped).
- angle1 changes 0->180 in the middle of a frame -> the current pulse is unchanged at 4000 clks; the next frame's pulse is 8000 clks; no runt pulse.
- ch_en=4'b0101 at the boundary, then toggled to 4'hF mid-frame -> pwm[1] and pwm[3] stay 0 for that frame and pulse from the following frame.
- rst asserted 1000 clks into a 6000-clk pulse -> pwm=0 in the same cycle; no pulse in the next frame; normal pulses resume from the second frame.
- SERVO_SLEW_EN defined, SLEW_STEP=2, angle1 set 0->10 -> successive frames use cur 2, 4, 6, 8, 10, 10, i.e. high times 4044, 4088, 4132, 4176, 4220, 4220 clks.

Source files
------------

// File: rtl/servo_pwm_quad.sv
// Four-channel hobby-servo PWM generator: angle -> 1..2 ms pulse in a shared frame.
// Optional build macro SERVO_SLEW_EN limits the angle change per frame to SLEW_STEP degrees.
module servo_pwm_quad #(
  parameter int CLK_HZ    = 50000000,
  parameter int PERIOD_US = 20000,
  parameter int MIN_US    = 1000,
  parameter int MAX_US    = 2000,
  parameter int ANGLE_MAX = 180,
  parameter int SLEW_STEP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] angle1,
  input  logic [7:0] angle2,
  input  logic [7:0] angle3,
  input  logic [7:0] angle4,
  input  logic [3:0] ch_en,
  output logic [3:0] pwm,
  output logic       frame_start
);

  localparam int DIV = CLK_HZ / 1000000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
  localparam int MW  = 8 + $clog2(MAX_US - MIN_US) + 1;

  // Product is held at MW bits so a*(MAX_US-MIN_US) cannot overflow before the divide.
  function automatic logic [CW-1:0] width_of(input logic [7:0] a);
    logic [MW-1:0] prod;
    prod = MW'(a) * MW'(MAX_US - MIN_US);
    return CW'(MIN_US) + CW'(prod / MW'(ANGLE_MAX));
  endfunction

  logic [PW-1:0] presc;
  logic [CW-1:0] us_cnt;
  logic          tick_us;
  logic          wrap;

  assign tick_us = (presc == PW'(DIV - 1));
  assign wrap    = tick_us && (us_cnt == CW'(PERIOD_US - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc       <= '0;
      us_cnt      <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (tick_us) begin
        presc  <= '0;
        us_cnt <= wrap ? '0 : us_cnt + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  logic [7:0] raw [4];
  logic [7:0] tgt [4];
  logic [7:0] src [4];

  assign raw[0] = angle1;
  assign raw[1] = angle2;
  assign raw[2] = angle3;
  assign raw[3] = angle4;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      tgt[i] = (raw[i] > 8'(ANGLE_MAX)) ? 8'(ANGLE_MAX) : raw[i];
    end
  end

`ifdef SERVO_SLEW_EN
  logic [7:0] cur     [4];
  logic [7:0] cur_nxt [4];

  // Each frame the tracked angle steps toward the target by at most SLEW_STEP.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cur_nxt[i] = cur[i];
      if (tgt[i] > cur[i]) begin
        cur_nxt[i] = ((tgt[i] - cur[i]) > 8'(SLEW_STEP)) ? cur[i] + 8'(SLEW_STEP) : tgt[i];
      end else if (tgt[i] < cur[i]) begin
        cur_nxt[i] = ((cur[i] - tgt[i]) > 8'(SLEW_STEP)) ? cur[i] - 8'(SLEW_STEP) : tgt[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cur[i] <= '0;
    end else if (wrap) begin
      for (int i = 0; i < 4; i++) cur[i] <= cur_nxt[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) src[i] = cur_nxt[i];
  end
`else
  logic unused_slew;
  assign unused_slew = (SLEW_STEP != 0);

  always_comb begin
    for (int i = 0; i < 4; i++) src[i] = tgt[i];
  end
`endif

  logic [CW-1:0] sh_w [4];
  logic [3:0]    sh_en;

  // Shadow state changes only on the frame boundary so no pulse is ever cut short.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_en <= '0;
      for (int i = 0; i < 4; i++) sh_w[i] <= CW'(MIN_US);
    end else if (wrap) begin
      sh_en <= ch_en;
      for (int i = 0; i < 4; i++) sh_w[i] <= width_of(src[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm <= '0;
    end else begin
      for (int i = 0; i < 4; i++) pwm[i] <= sh_en[i] & (us_cnt < sh_w[i]);
    end
  end

endmodule

// File: tb/tb_servo_pwm_quad.sv
// Bench for servo_pwm_quad: per-frame pulse widths checked against an arithmetic frame model.
// Frame parameters are shrunk so that many frames fit in a short run.
module tb_servo_pwm_quad;

  localparam int CLK_HZ    = 4000000;
  localparam int DIV       = 4;
  localparam int PERIOD_US = 300;
  localparam int MIN_US    = 100;
  localparam int MAX_US    = 200;
  localparam int ANGLE_MAX = 180;
  localparam int SLEW_STEP = 2;
  localparam int F         = PERIOD_US * DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] angle1, angle2, angle3, angle4;
  logic [3:0] ch_en;
  logic [3:0] pwm;
  logic       frame_start;

  servo_pwm_quad #(
    .CLK_HZ(CLK_HZ), .PERIOD_US(PERIOD_US), .MIN_US(MIN_US),
    .MAX_US(MAX_US), .ANGLE_MAX(ANGLE_MAX), .SLEW_STEP(SLEW_STEP)
  ) dut (
    .clk(clk), .rst(rst),
    .angle1(angle1), .angle2(angle2), .angle3(angle3), .angle4(angle4),
    .ch_en(ch_en), .pwm(pwm), .frame_start(frame_start)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_edge   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, n_edge);
  endtask

  function automatic int clamp_angle(input int a);
    return (a > ANGLE_MAX) ? ANGLE_MAX : a;
  endfunction

  function automatic int ref_width_us(input int a);
    return MIN_US + (clamp_angle(a) * (MAX_US - MIN_US)) / ANGLE_MAX;
  endfunction

  // reference model: expected high clocks per channel for the frame in progress
  int exp_hi [4];
  int hi_cnt [4];
  bit contig [4];
  int cur    [4];

  always @(negedge clk) begin
    int off;
    int a [4];
    int w;
    if (rst) begin
      n_edge = 0;
      for (int i = 0; i < 4; i++) begin
        exp_hi[i] = 0; hi_cnt[i] = 0; contig[i] = 1'b1; cur[i] = 0;
      end
    end else begin
      n_edge++;
      off = (n_edge - 1) % F;
      check("frame_start", 32'(frame_start), 32'((n_edge % F) == 0));
      for (int i = 0; i < 4; i++) begin
        if (pwm[i]) begin
          if (hi_cnt[i] != off) contig[i] = 1'b0;
          hi_cnt[i]++;
        end
      end
      if ((n_edge % F) == 0) begin
        for (int i = 0; i < 4; i++) begin
          check($sformatf("high_clks[%0d]", i), 32'(hi_cnt[i]), 32'(exp_hi[i]));
          check($sformatf("contiguous[%0d]", i), 32'(contig[i]), 32'd1);
          hi_cnt[i] = 0;
          contig[i] = 1'b1;
        end
        a[0] = int'(angle1); a[1] = int'(angle2); a[2] = int'(angle3); a[3] = int'(angle4);
        for (int i = 0; i < 4; i++) begin
`ifdef SERVO_SLEW_EN
          if (clamp_angle(a[i]) > cur[i])
            cur[i] += (clamp_angle(a[i]) - cur[i] > SLEW_STEP) ? SLEW_STEP : clamp_angle(a[i]) - cur[i];
          else
            cur[i] -= (cur[i] - clamp_angle(a[i]) > SLEW_STEP) ? SLEW_STEP : cur[i] - clamp_angle(a[i]);
          w = ref_width_us(cur[i]);
`else
          w = ref_width_us(a[i]);
`endif
          exp_hi[i] = ch_en[i] ? w * DIV : 0;
        end
      end
    end
  end

  // driver tasks
  task automatic goto_edge(input int target);
    int guard = 0;
    while (n_edge != target && guard < 4 * F) begin
      @(negedge clk); #1;
      guard++;
    end
    if (n_edge != target) check("goto_timeout", 32'(n_edge), 32'(target));
  endtask

  task automatic set_angles(input int a1, input int a2, input int a3, input int a4);
    angle1 = 8'(a1); angle2 = 8'(a2); angle3 = 8'(a3); angle4 = 8'(a4);
  endtask

  initial begin
    rst = 1'b1;
    set_angles(90, 90, 90, 90);
    ch_en = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    check("reset_pwm", 32'(pwm), 32'd0);
    check("reset_frame_start", 32'(frame_start), 32'd0);
    rst = 1'b0;

    goto_edge(2 * F - 1);
    set_angles(0, 180, 1, 255);
    goto_edge(2 * F + F / 2);
    angle1 = 8'd180;
    goto_edge(3 * F - 1);
    ch_en = 4'b0101;
    goto_edge(3 * F + F / 2);
    ch_en = 4'hF;

    for (int k = 5; k <= 14; k++) begin
      goto_edge((k - 1) * F + F / 2 + 1 + int'($urandom_range(0, F / 2 - 3)));
      set_angles($urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 255), $urandom_range(0, 255));
      ch_en = 4'($urandom_range(0, 15));
      goto_edge(k * F + 1 + int'($urandom_range(0, F / 2 - 2)));
      set_angles($urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 255), $urandom_range(0, 255));
      ch_en = 4'($urandom_range(0, 15));
    end

    goto_edge(15 * F - 1);
    set_angles(90, 90, 90, 90);
    ch_en = 4'hF;
    goto_edge(15 * F + 200);
    check("pre_reset_pwm", 32'(pwm), 32'hF);
    rst = 1'b1;
    #1;
    check("async_reset_pwm", 32'(pwm), 32'd0);
    check("async_reset_frame_start", 32'(frame_start), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;

    goto_edge(3 * F + 5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
